rx_frame_ctrl: RTL
==================

# rx_frame_ctrl

UART receive sequencer. It oversamples the serial `rx` line, deserializes one frame (start, 8 data bits LSB-first, optional parity, stop) and presents the frame fields plus a one-cycle `recieved_flag` strobe to the downstream error-check unit. It captures the returned `error_flag` with the data byte into an output register, which it offers to the consumer over a valid/ready handshake with overrun detection. It sits between the pad-side `rx` line and the receive consumer (FIFO/bus bridge).

## Interface
- OVERSAMPLE, 16, `baud_tick` pulses per bit period; even, ≥4.
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- baud_tick  in  1  one-cycle enable at OVERSAMPLE × baud rate.
- rx  in  1  asynchronous serial input, idle high.
- parity_type  in  2  01 odd, 10 even, 00/11 no parity bit in frame.
- start_bit  out  1  sampled start bit, to error check.
- parity_bit  out  1  sampled parity bit; forced 1 when no parity.
- stop_bit  out  1  sampled stop bit.
- raw_data  out  8  deserialized data byte.
- recieved_flag  out  1  one-cycle strobe: fields complete, error check valid.
- error_flag  in  3  {stop,start,parity} from error check, valid while recieved_flag=1.
- rx_data  out  8  delivered byte.
- rx_err  out  3  error_flag captured with rx_data.
- rx_valid  out  1  rx_data/rx_err valid.
- rx_ready  in  1  consumer accepts when rx_valid && rx_ready.
- overrun  out  1  sticky: a frame overwrote an unaccepted one.
- busy  out  1  high in any state except IDLE.

## Operation
- rx passes through a 2-flop synchronizer (flops reset to 1). All sampling uses the synchronized value `rxs`.
- Tick counter `cnt` (log2 OVERSAMPLE bits) advances only on baud_tick. It clears on every state change.
- `parity_type` is latched on IDLE→START. A mid-frame change has no effect on that frame.
- States:
  - IDLE: the block arms once `rxs`=1 has been observed. The arm flag resets to 0, so a line held low out of reset starts nothing. On an armed 1→0 edge of `rxs`, go to START.
  - START: on the OVERSAMPLE/2-th tick, sample `rxs`.
    - If 1 (false start): return to IDLE with no output and no strobe.
    - If 0: start_bit←0, go to DATA with bit index 0.
  - DATA: sample on every OVERSAMPLE-th tick. raw_data[idx]←rxs, LSB first. After idx 7, go to PARITY if parity is enabled, else STOP.
  - PARITY: sample on the OVERSAMPLE-th tick into parity_bit, go to STOP.
  - STOP: sample on the OVERSAMPLE-th tick into stop_bit, go to CHECK. A stop value of 0 is still delivered, not discarded.
  - CHECK: exactly one cycle with recieved_flag=1. Capture rx_data←raw_data, rx_err←error_flag, rx_valid←1. Then go to IDLE, which requires a fresh armed 1→0 edge before the next frame.
- No-parity frames: parity_bit is held 1, so the error check reports parity_flag=0.
- Handshake: a transfer occurs when rx_valid && rx_ready. After a transfer, rx_valid←0 unless CHECK occurs in the same cycle.
- Capture in CHECK with rx_valid=1:
  - rx_ready=1: the old word transfers, the new word loads, rx_valid stays 1, no overrun.
  - rx_ready=0: the new word overwrites the old and overrun←1.
- overrun clears on the next completed transfer.
- rx_data and rx_err hold their values while rx_valid=0.

## Timing
- Reset values: start_bit 0, parity_bit 1, stop_bit 1, raw_data 0, recieved_flag 0, rx_data 0, rx_err 0, rx_valid 0, overrun 0, busy 0, state IDLE.
- An assertion of reset_n=0 mid-frame aborts immediately. No strobe is generated and the partial frame is lost.
- rx→rxs latency is 2 clocks.
- Stop-sample edge → CHECK on the next cycle → rx_valid=1 on the cycle after CHECK.
- recieved_flag is a decode of the CHECK state, so it is glitch-free and never high for 2 consecutive cycles.
- baud_tick is ignored in CHECK and IDLE.
- busy rises the cycle after the edge is detected and falls the cycle after CHECK or a false start.

## Test plan
- 8N... even-parity frame: parity_type=10, send 0xA5 with parity 0, stop 1 → one recieved_flag pulse, rx_data=0xA5, rx_err=000, rx_valid=1.
- Parity error: parity_type=01, send 0xA5 with parity 0 → rx_err=001. Stop bit 0 on a further frame → rx_err=100; that frame is still delivered.
- No parity: parity_type=00, send 0x3C as a 10-bit frame → parity_bit=1, rx_err=000. A second frame immediately after the stop bit is received correctly.
- False start: rx low for OVERSAMPLE/4 ticks then high → busy pulses, returns to IDLE, no recieved_flag, no rx_valid.
- Overrun: send 0x11 then 0x22 with rx_ready=0 → rx_data=0x22, overrun=1. Assert rx_ready one cycle → rx_valid=0, overrun=0.
- Reset/arm: assert reset_n=0 during DATA bit 3 → all outputs take their reset values. Release with rx held low → no frame until rx goes high then low.

Source files
------------

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: oversampling UART receive sequencer. Deserializes one frame
// (start, 8 data bits LSB-first, optional parity, stop), strobes the fields to
// the downstream error checker, then holds the byte and its error flags in an
// output register offered over valid/ready, with sticky overrun detection.
module rx_frame_ctrl #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       baud_tick,
  input  logic       rx,
  input  logic [1:0] parity_type,
  output logic       start_bit,
  output logic       parity_bit,
  output logic       stop_bit,
  output logic [7:0] raw_data,
  output logic       recieved_flag,
  input  logic [2:0] error_flag,
  output logic [7:0] rx_data,
  output logic [2:0] rx_err,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] CHECK  = 3'd5;

  // Synchronizer and arming
  logic [1:0]    sync_reg;
  logic          rxs;
  logic [1:0]    primed_reg;
  logic          armed_reg;

  // Sequencer
  logic [2:0]    state_reg;
  logic [2:0]    state_next;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    bit_idx_reg;
  logic          par_en_reg;
  logic          half_hit;
  logic          full_hit;
  logic          counting;

  // Frame fields
  logic          start_bit_reg;
  logic          parity_bit_reg;
  logic          stop_bit_reg;
  logic [7:0]    raw_data_reg;
  logic          recv_flag_reg;

  // Output register
  logic [7:0]    rx_data_reg;
  logic [2:0]    rx_err_reg;
  logic          rx_valid_reg;
  logic          overrun_reg;
  logic          transfer;

  assign rxs      = sync_reg[1];
  assign half_hit = baud_tick && (cnt_reg == HALF_LAST);
  assign full_hit = baud_tick && (cnt_reg == FULL_LAST);
  assign counting = (state_reg == START) || (state_reg == DATA) ||
                    (state_reg == PARITY) || (state_reg == STOP);
  assign transfer = rx_valid_reg && rx_ready;

  // Two-flop synchronizer on rx; idles high so reset looks like an idle line
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rx};
    end
  end

  // Marks when the synchronizer holds real line samples rather than reset values
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      primed_reg <= 2'b00;
    end else begin
      primed_reg <= {primed_reg[0], 1'b1};
    end
  end

  // Arm on an observed idle-high line in IDLE; disarm once a frame begins
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      armed_reg <= 1'b0;
    end else if (state_reg != IDLE || state_next == START) begin
      armed_reg <= 1'b0;
    end else if (rxs && primed_reg[1]) begin
      armed_reg <= 1'b1;
    end
  end

  // Next-state decode for the frame sequencer
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (armed_reg && !rxs) begin
          state_next = START;
        end
      end
      START: begin
        if (half_hit) begin
          state_next = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (full_hit && bit_idx_reg == 3'd7) begin
          state_next = par_en_reg ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (full_hit) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (full_hit) begin
          state_next = CHECK;
        end
      end
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Tick counter: cleared on state change, wraps once per bit inside DATA
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (state_next != state_reg) begin
      cnt_reg <= '0;
    end else if (counting && baud_tick) begin
      cnt_reg <= (cnt_reg == FULL_LAST) ? '0 : cnt_reg + CW'(1);
    end
  end

  // Latch the parity mode and reset the bit index at frame start
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      par_en_reg  <= 1'b0;
      bit_idx_reg <= 3'd0;
    end else if (state_reg == IDLE && state_next == START) begin
      par_en_reg  <= (parity_type == 2'b01) || (parity_type == 2'b10);
      bit_idx_reg <= 3'd0;
    end else if (state_reg == DATA && full_hit) begin
      bit_idx_reg <= bit_idx_reg + 3'd1;
    end
  end

  // Frame field capture at each bit's sample point
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      start_bit_reg  <= 1'b0;
      parity_bit_reg <= 1'b1;
      stop_bit_reg   <= 1'b1;
      raw_data_reg   <= 8'h00;
    end else begin
      case (state_reg)
        IDLE: begin
          // Frames without a parity bit present a neutral parity of 1
          if (state_next == START &&
              !((parity_type == 2'b01) || (parity_type == 2'b10))) begin
            parity_bit_reg <= 1'b1;
          end
        end
        START: begin
          if (half_hit && !rxs) begin
            start_bit_reg <= rxs;
          end
        end
        DATA: begin
          if (full_hit) begin
            raw_data_reg[bit_idx_reg] <= rxs;
          end
        end
        PARITY: begin
          if (full_hit) begin
            parity_bit_reg <= rxs;
          end
        end
        STOP: begin
          if (full_hit) begin
            stop_bit_reg <= rxs;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered CHECK decode so the strobe is a clean single-cycle pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      recv_flag_reg <= 1'b0;
    end else begin
      recv_flag_reg <= (state_next == CHECK);
    end
  end

  // Output word register with valid/ready handshake and sticky overrun
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_data_reg  <= 8'h00;
      rx_err_reg   <= 3'b000;
      rx_valid_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else if (state_reg == CHECK) begin
      rx_data_reg  <= raw_data_reg;
      rx_err_reg   <= error_flag;
      rx_valid_reg <= 1'b1;
      if (rx_valid_reg && !rx_ready) begin
        overrun_reg <= 1'b1;
      end else if (transfer) begin
        overrun_reg <= 1'b0;
      end
    end else if (transfer) begin
      rx_valid_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end
  end

  assign start_bit     = start_bit_reg;
  assign parity_bit    = parity_bit_reg;
  assign stop_bit      = stop_bit_reg;
  assign raw_data      = raw_data_reg;
  assign recieved_flag = recv_flag_reg;
  assign rx_data       = rx_data_reg;
  assign rx_err        = rx_err_reg;
  assign rx_valid      = rx_valid_reg;
  assign overrun       = overrun_reg;
  assign busy          = (state_reg != IDLE);

endmodule
